// File: rtl/cycle_cooling_fan_ctrl.sv
// Cycle cooling fan controller: 5-state dwell-qualified FSM driving a registered 3-bit fan mode.
// Optional manual override of fan_mode is enabled by defining CCS_MANUAL_OVERRIDE_EN.
module cycle_cooling_fan_ctrl #(
    parameter int SENS_W  = 8,
    parameter int CAL_TH  = 1,
    parameter int TEMP_TH = 1,
    parameter int PRES_TH = 1,
    parameter int AIR_TH  = 1,
    parameter int HYST    = 0,
    parameter int DWELL_W = 4,
    parameter int T_IDLE  = 2,
    parameter int T_WARM  = 3,
    parameter int T_ACT   = 5,
    parameter int T_BOOST = 2,
    parameter int T_COOL  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [SENS_W-1:0] calorie,
    input  logic [SENS_W-1:0] temperature,
    input  logic [SENS_W-1:0] pressure,
    input  logic [SENS_W-1:0] air_pressure,
`ifdef CCS_MANUAL_OVERRIDE_EN
    input  logic              man_en,
    input  logic [2:0]        man_mode,
`endif
    output logic [2:0]        fan_mode,
    output logic [2:0]        state_o,
    output logic              fan_change
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WARMUP   = 3'd1;
    localparam logic [2:0] S_ACTIVE   = 3'd2;
    localparam logic [2:0] S_BOOST    = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;

    localparam logic [SENS_W-1:0] CAL_HI  = SENS_W'(CAL_TH);
    localparam logic [SENS_W-1:0] TEMP_HI = SENS_W'(TEMP_TH);
    localparam logic [SENS_W-1:0] PRES_HI = SENS_W'(PRES_TH);
    localparam logic [SENS_W-1:0] AIR_HI  = SENS_W'(AIR_TH);
    // De-escalate thresholds sit HYST below the escalate ones, floored at zero
    localparam logic [SENS_W-1:0] CAL_LO  = (CAL_TH  > HYST) ? SENS_W'(CAL_TH  - HYST) : '0;
    localparam logic [SENS_W-1:0] TEMP_LO = (TEMP_TH > HYST) ? SENS_W'(TEMP_TH - HYST) : '0;

    // Terminal counts (T-1); a dwell of 0 is treated as 1
    localparam logic [DWELL_W-1:0] L_IDLE  = (T_IDLE  > 1) ? DWELL_W'(T_IDLE  - 1) : '0;
    localparam logic [DWELL_W-1:0] L_WARM  = (T_WARM  > 1) ? DWELL_W'(T_WARM  - 1) : '0;
    localparam logic [DWELL_W-1:0] L_ACT   = (T_ACT   > 1) ? DWELL_W'(T_ACT   - 1) : '0;
    localparam logic [DWELL_W-1:0] L_BOOST = (T_BOOST > 1) ? DWELL_W'(T_BOOST - 1) : '0;
    localparam logic [DWELL_W-1:0] L_COOL  = (T_COOL  > 1) ? DWELL_W'(T_COOL  - 1) : '0;

    logic [2:0]         state, state_nxt;
    logic [DWELL_W-1:0] up_cnt, dn_cnt, up_nxt, dn_nxt;
    logic [DWELL_W-1:0] up_lim, dn_lim;
    logic [2:0]         up_tgt, dn_tgt;
    logic               up_cond, dn_cond, illegal;
    logic [2:0]         fan_nxt;

    function automatic logic [2:0] mode_of(input logic [2:0] s);
        case (s)
            S_WARMUP:   mode_of = 3'b001;
            S_ACTIVE:   mode_of = 3'b010;
            S_BOOST:    mode_of = 3'b011;
            S_COOLDOWN: mode_of = 3'b001;
            default:    mode_of = 3'b000;
        endcase
    endfunction

    always_comb begin
        up_cond = 1'b0;
        dn_cond = 1'b0;
        up_lim  = '0;
        dn_lim  = '0;
        up_tgt  = state;
        dn_tgt  = state;
        illegal = 1'b0;
        case (state)
            S_IDLE: begin
                up_cond = calorie > CAL_HI;       up_lim = L_IDLE;  up_tgt = S_WARMUP;
            end
            S_WARMUP: begin
                up_cond = temperature > TEMP_HI;  up_lim = L_WARM;  up_tgt = S_ACTIVE;
                dn_cond = calorie <= CAL_LO;      dn_lim = L_COOL;  dn_tgt = S_IDLE;
            end
            S_ACTIVE: begin
                up_cond = pressure < PRES_HI;     up_lim = L_ACT;   up_tgt = S_BOOST;
                dn_cond = temperature <= TEMP_LO; dn_lim = L_COOL;  dn_tgt = S_COOLDOWN;
            end
            S_BOOST: begin
                dn_cond = air_pressure <= AIR_HI; dn_lim = L_BOOST; dn_tgt = S_ACTIVE;
            end
            S_COOLDOWN: begin
                up_cond = temperature > TEMP_HI;  up_lim = '0;      up_tgt = S_ACTIVE;
                dn_cond = 1'b1;                   dn_lim = L_COOL;  dn_tgt = S_IDLE;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        up_nxt    = up_cnt;
        dn_nxt    = dn_cnt;
        if (illegal) begin
            state_nxt = S_IDLE;
            up_nxt    = '0;
            dn_nxt    = '0;
        end else if (tick) begin
            // Up path has priority when both dwells complete on the same tick
            if (up_cond && up_cnt == up_lim)
                state_nxt = up_tgt;
            else if (dn_cond && dn_cnt == dn_lim)
                state_nxt = dn_tgt;
            if (state_nxt != state) begin
                up_nxt = '0;
                dn_nxt = '0;
            end else begin
                up_nxt = !up_cond ? '0 : (&up_cnt) ? up_cnt : up_cnt + 1'b1;
                dn_nxt = !dn_cond ? '0 : (&dn_cnt) ? dn_cnt : dn_cnt + 1'b1;
            end
        end
    end

`ifdef CCS_MANUAL_OVERRIDE_EN
    assign fan_nxt = man_en ? man_mode : mode_of(state_nxt);
`else
    assign fan_nxt = mode_of(state_nxt);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            up_cnt     <= '0;
            dn_cnt     <= '0;
            fan_mode   <= 3'b000;
            fan_change <= 1'b0;
        end else begin
            state      <= state_nxt;
            up_cnt     <= up_nxt;
            dn_cnt     <= dn_nxt;
            fan_mode   <= fan_nxt;
            fan_change <= fan_nxt != fan_mode;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_cycle_cooling_fan_ctrl.sv
// Randomized bench for cycle_cooling_fan_ctrl against a consecutive-tick dwell model.
module tb_cycle_cooling_fan_ctrl;

    localparam int SENS_W = 8;
    localparam int CAL_TH = 5, TEMP_TH = 6, PRES_TH = 4, AIR_TH = 4, HYST = 2;
    localparam int T_IDLE = 2, T_WARM = 3, T_ACT = 3, T_BOOST = 2, T_COOL = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic [SENS_W-1:0] calorie = '0, temperature = '0, pressure = '0, air_pressure = '0;
    logic [2:0]        fan_mode, state_o;
    logic              fan_change;
`ifdef CCS_MANUAL_OVERRIDE_EN
    logic              man_en = 1'b0;
    logic [2:0]        man_mode = 3'b000;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // model: state as spec encoding, counts of consecutive ticks each condition has held
    int m_state = 0, m_up = 0, m_dn = 0, m_fan = 0, m_chg = 0;

    cycle_cooling_fan_ctrl #(
        .SENS_W(SENS_W), .CAL_TH(CAL_TH), .TEMP_TH(TEMP_TH), .PRES_TH(PRES_TH),
        .AIR_TH(AIR_TH), .HYST(HYST), .DWELL_W(4), .T_IDLE(T_IDLE), .T_WARM(T_WARM),
        .T_ACT(T_ACT), .T_BOOST(T_BOOST), .T_COOL(T_COOL)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .calorie(calorie), .temperature(temperature),
        .pressure(pressure), .air_pressure(air_pressure),
`ifdef CCS_MANUAL_OVERRIDE_EN
        .man_en(man_en), .man_mode(man_mode),
`endif
        .fan_mode(fan_mode), .state_o(state_o), .fan_change(fan_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int mode_of(input int s);
        case (s)
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int lo_th(input int th);
        return (th - HYST < 0) ? 0 : th - HYST;
    endfunction

    task automatic model_step(input bit tk, input int cal, input int tmp, input int prs, input int air);
        int prev_fan, ut, dt, utgt, dtgt, nxt;
        bit uc, dc;
        prev_fan = mode_of(m_state);
        if (tk) begin
            uc = 0; dc = 0; ut = 1; dt = 1; utgt = m_state; dtgt = m_state;
            case (m_state)
                0: begin uc = cal > CAL_TH; ut = T_IDLE; utgt = 1; end
                1: begin uc = tmp > TEMP_TH; ut = T_WARM; utgt = 2;
                         dc = cal <= lo_th(CAL_TH); dt = T_COOL; dtgt = 0; end
                2: begin uc = prs < PRES_TH; ut = T_ACT; utgt = 3;
                         dc = tmp <= lo_th(TEMP_TH); dt = T_COOL; dtgt = 4; end
                3: begin dc = air <= AIR_TH; dt = T_BOOST; dtgt = 2; end
                default: begin uc = tmp > TEMP_TH; ut = 1; utgt = 2;
                         dc = 1; dt = T_COOL; dtgt = 0; end
            endcase
            m_up = uc ? ((m_up < 15) ? m_up + 1 : 15) : 0;
            m_dn = dc ? ((m_dn < 15) ? m_dn + 1 : 15) : 0;
            nxt = m_state;
            if (uc && m_up >= ut) nxt = utgt;
            else if (dc && m_dn >= dt) nxt = dtgt;
            if (nxt != m_state) begin
                m_state = nxt; m_up = 0; m_dn = 0;
            end
        end
        m_fan = mode_of(m_state);
        m_chg = (m_fan != prev_fan) ? 1 : 0;
    endtask

    // drive one cycle (inputs set after a negedge), then check one time unit past the edge
    task automatic cycle(input bit tk, input int cal, input int tmp, input int prs, input int air);
        tick = tk;
        calorie = SENS_W'(cal); temperature = SENS_W'(tmp);
        pressure = SENS_W'(prs); air_pressure = SENS_W'(air);
        model_step(tk, cal, tmp, prs, air);
        @(posedge clk); #1;
        chk("state", int'(state_o), m_state);
        chk("fan_mode", int'(fan_mode), m_fan);
        chk("fan_change", int'(fan_change), m_chg);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_state = 0; m_up = 0; m_dn = 0; m_fan = 0; m_chg = 0;
    endtask

    int cal_r, tmp_r, prs_r, air_r;

    initial begin
        #1;
        chk("reset_state", int'(state_o), 0);
        chk("reset_fan", int'(fan_mode), 0);
        chk("reset_change", int'(fan_change), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();

        // climb IDLE -> WARMUP -> ACTIVE -> BOOST
        repeat (2) cycle(1, 9, 9, 9, 9);
        chk("warmup_reached", int'(state_o), 1);
        repeat (3) cycle(1, 9, 9, 0, 9);
        chk("active_reached", int'(fan_mode), 2);
        repeat (3) cycle(1, 9, 9, 0, 9);
        chk("boost_reached", int'(state_o), 3);

        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_state", int'(state_o), 0);
        chk("async_rst_fan", int'(fan_mode), 0);
        chk("async_rst_change", int'(fan_change), 0);
        @(negedge clk);
        rst = 1'b0;

        // glitch filter in IDLE
        cycle(1, 9, 0, 9, 9); cycle(1, 0, 0, 9, 9); cycle(1, 9, 0, 9, 9);
        chk("glitch_idle", int'(state_o), 0);
        repeat (2) cycle(1, 9, 0, 9, 9);

        // back to ACTIVE, then tie between up and down dwells (equal lengths)
        repeat (3) cycle(1, 9, 9, 9, 9);
        repeat (3) cycle(1, 9, 0, 0, 9);
        chk("tie_up_wins", int'(state_o), 3);
        repeat (2) cycle(1, 9, 9, 9, 0);
        chk("boost_to_active", int'(fan_mode), 2);

        // tick held low with every condition true
        repeat (100) cycle(0, 9, 0, 0, 0);
        chk("tick_low_hold", int'(state_o), 2);

        // randomized sticky sensors
        cal_r = 0; tmp_r = 0; prs_r = 9; air_r = 9;
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) cal_r = $urandom_range(0, 10);
            if ($urandom_range(0, 3) == 0) tmp_r = $urandom_range(0, 10);
            if ($urandom_range(0, 3) == 0) prs_r = $urandom_range(0, 10);
            if ($urandom_range(0, 3) == 0) air_r = $urandom_range(0, 10);
            cycle($urandom_range(0, 3) != 0, cal_r, tmp_r, prs_r, air_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
